// File: rtl/alu_queue_sched.sv
// Command queue feeding a small add/sub/mul ALU through a four-state scheduler.
// Results are held in RESP until the consumer takes them; commands retire in order.
module alu_queue_sched #(
    parameter int WIDTH   = 8,
    parameter int Q_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_x,
    input  logic [WIDTH-1:0]           cmd_z,
    output logic                       cmd_ready,
    output logic [$clog2(Q_DEPTH):0]   number_queued,
    output logic                       q_full,
    output logic [7:0]                 drop_cnt,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*WIDTH-1:0]         res_y,
    output logic                       res_err
);
    localparam int PW = $clog2(Q_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(Q_DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, MUL2, RESP} state_t;

    logic [1:0]       r_q_op [Q_DEPTH];
    logic [WIDTH-1:0] r_q_x  [Q_DEPTH];
    logic [WIDTH-1:0] r_q_z  [Q_DEPTH];
    logic [PW-1:0]    r_head, r_tail;
    logic [PW:0]      r_count;
    logic [7:0]       r_drop;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_x, r_z;
    logic [2*WIDTH-1:0] r_res_y;
    logic             r_res_valid, r_res_err;

    logic             w_push, w_pop, w_drop;
    logic [2*WIDTH-1:0] w_xe, w_ze;

    assign cmd_ready     = (r_count < DEPTH_C);
    assign q_full        = (r_count == DEPTH_C);
    assign number_queued = r_count;
    assign drop_cnt      = r_drop;
    assign res_valid     = r_res_valid;
    assign res_y         = r_res_y;
    assign res_err       = r_res_err;

    assign w_push = cmd_valid && cmd_ready;
    assign w_drop = cmd_valid && !cmd_ready;
    assign w_pop  = (r_state == IDLE) && (r_count != '0);
    assign w_xe   = {{WIDTH{1'b0}}, r_x};
    assign w_ze   = {{WIDTH{1'b0}}, r_z};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_op[r_tail] <= cmd_op;
            r_q_x[r_tail]  <= cmd_x;
            r_q_z[r_tail]  <= cmd_z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    // res_valid is raised on the first RESP cycle's edge, so the result is
    // visible one cycle after it is written into r_res_y.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_x         <= '0;
            r_z         <= '0;
            r_res_y     <= '0;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_pop) begin
                    r_op      <= r_q_op[r_head];
                    r_x       <= r_q_x[r_head];
                    r_z       <= r_q_z[r_head];
                    r_res_err <= 1'b0;
                    r_state   <= EXEC;
                end
                EXEC: case (r_op)
                    2'd0: begin r_res_y <= w_xe + w_ze; r_state <= RESP; end
                    2'd1: begin r_res_y <= w_xe - w_ze; r_state <= RESP; end
                    2'd2: r_state <= MUL2;
                    default: begin
                        r_res_y   <= '0;
                        r_res_err <= 1'b1;
                        r_state   <= RESP;
                    end
                endcase
                MUL2: begin
                    r_res_y <= w_xe * w_ze;
                    r_state <= RESP;
                end
                RESP: begin
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_queue_sched.sv
// Bench for alu_queue_sched: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model (command queue + latency countdown).
module tb_alu_queue_sched;
    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_x, cmd_z;
    logic        cmd_ready;
    logic [2:0]  number_queued;
    logic        q_full;
    logic [7:0]  drop_cnt;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_y;
    logic        res_err;

    alu_queue_sched #(.WIDTH(8), .Q_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_z(cmd_z), .cmd_ready(cmd_ready),
        .number_queued(number_queued), .q_full(q_full), .drop_cnt(drop_cnt),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] x;
        logic [7:0] z;
    } cmd_t;

    int total = 0;
    int bad   = 0;

    // Model: waiting commands, the one in flight, and cycles until its result shows.
    cmd_t        mq[$];
    cmd_t        cur;
    bit          busy, mvalid, mrst;
    int          wt, mdrop;
    logic [15:0] ey;
    logic        eerr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] calc(input cmd_t c);
        case (c.op)
            2'd0:    return 16'(c.x) + 16'(c.z);
            2'd1:    return 16'(c.x) - 16'(c.z);
            2'd2:    return 16'(c.x) * 16'(c.z);
            default: return 16'd0;
        endcase
    endfunction

    task automatic compare_all();
        chk("ready", 32'(cmd_ready), 32'(mq.size() < QD));
        chk("nq", 32'(number_queued), 32'(mq.size()));
        chk("full", 32'(q_full), 32'(mq.size() == QD));
        chk("drop", 32'(drop_cnt), 32'(mdrop));
        chk("rvalid", 32'(res_valid), 32'(mvalid));
        if (mvalid) begin
            chk("ry", 32'(res_y), 32'(ey));
            chk("rerr", 32'(res_err), 32'(eerr));
        end
        if (mrst) begin
            chk("ry_rst", 32'(res_y), 32'd0);
            chk("rerr_rst", 32'(res_err), 32'd0);
        end
    endtask

    task automatic model_step(input logic v, input cmd_t c, input logic rr, input logic rs);
        bit can_push;
        if (rs) begin
            mq.delete();
            busy = 0; mvalid = 0; mdrop = 0; mrst = 1; wt = 0;
        end else begin
            can_push = (mq.size() < QD);
            if (!busy) begin
                if (mq.size() > 0) begin
                    cur  = mq.pop_front();
                    busy = 1;
                    wt   = (cur.op == 2'd2) ? 3 : 2;
                    mrst = 0;
                end
            end else if (mvalid) begin
                if (rr) begin busy = 0; mvalid = 0; end
            end else begin
                wt--;
                if (wt == 0) begin
                    mvalid = 1;
                    ey     = calc(cur);
                    eerr   = (cur.op == 2'd3);
                end
            end
            if (v) begin
                if (can_push) mq.push_back(c);
                else if (mdrop < 255) mdrop++;
            end
        end
    endtask

    // One clock: check state, drive inputs, advance the model, land on the next negedge.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] x,
                       input logic [7:0] z, input logic rr, input logic rs);
        cmd_t c;
        compare_all();
        c = '{op: op, x: x, z: z};
        cmd_valid = v; cmd_op = op; cmd_x = x; cmd_z = z;
        res_ready = rr; rst = rs;
        model_step(v, c, rr, rs);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 8'd0, 8'd0, rr, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_z = '0;
        res_ready = 1'b0;
        busy = 0; mvalid = 0; mrst = 1; wt = 0; mdrop = 0; ey = '0; eerr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_nq", 32'(number_queued), 32'd0);

        // single add, result three edges after acceptance
        cyc(1'b1, 2'd0, 8'd200, 8'd100, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("add_early", 32'(res_valid), 32'd0);
        idle(1, 1'b1);
        chk("add_v", 32'(res_valid), 32'd1);
        chk("add_y", 32'(res_y), 32'd300);
        chk("add_err", 32'(res_err), 32'd0);
        idle(2, 1'b1);

        cyc(1'b1, 2'd1, 8'd5, 8'd7, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("sub_y", 32'(res_y), 32'hFFFE);
        idle(2, 1'b1);

        cyc(1'b1, 2'd2, 8'd255, 8'd255, 1'b1, 1'b0);
        idle(3, 1'b1);
        chk("mul_early", 32'(res_valid), 32'd0);
        idle(1, 1'b1);
        chk("mul_v", 32'(res_valid), 32'd1);
        chk("mul_y", 32'(res_y), 32'hFE01);
        idle(2, 1'b1);

        // invalid opcode, then a normal add clears the error flag
        cyc(1'b1, 2'd3, 8'd9, 8'd9, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 8'd1, 8'd1, 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("inv_y", 32'(res_y), 32'd0);
        chk("inv_err", 32'(res_err), 32'd1);
        idle(4, 1'b1);
        chk("aft_y", 32'(res_y), 32'd2);
        chk("aft_err", 32'(res_err), 32'd0);
        idle(2, 1'b1);

        // backpressure: held result stays put, drops one cycle after release
        cyc(1'b1, 2'd0, 8'd3, 8'd4, 1'b0, 1'b0);
        idle(3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_v", 32'(res_valid), 32'd1);
            chk("bp_y", 32'(res_y), 32'd7);
            idle(1, 1'b0);
        end
        idle(1, 1'b1);
        chk("bp_rel", 32'(res_valid), 32'd0);
        idle(2, 1'b1);

        // fill and overflow: five accepted, sixth dropped, drain in order
        cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'd0, 8'(i + 1), 8'd10, 1'b0, 1'b0);
        chk("ovf_ready", 32'(cmd_ready), 32'd0);
        chk("ovf_full", 32'(q_full), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd1);
        idle(30, 1'b1);
        chk("ovf_empty", 32'(number_queued), 32'd0);

        // reset while a mul is in MUL2 with three commands waiting
        cyc(1'b1, 2'd0, 8'd1, 8'd2, 1'b0, 1'b0);
        idle(3, 1'b0);
        cyc(1'b1, 2'd2, 8'd12, 8'd13, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 8'(i), 8'd1, 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        chk("mr_nq", 32'(number_queued), 32'd3);
        cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 1'b1);
        chk("mr_nq0", 32'(number_queued), 32'd0);
        chk("mr_v", 32'(res_valid), 32'd0);
        chk("mr_y", 32'(res_y), 32'd0);
        chk("mr_rdy", 32'(cmd_ready), 32'd1);
        idle(10, 1'b1);

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            cyc(1'(($urandom % 3) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
                1'(($urandom % 4) != 0), 1'(($urandom % 250) == 0));

        // drop counter saturation
        cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cyc(1'b1, 2'd1, 8'd1, 8'd1, 1'b0, 1'b0);
        chk("drop_sat", 32'(drop_cnt), 32'd255);
        idle(1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_queue_sched.md
ALU_QUEUE_SCHED -- requirements
Module: alu_queue_sched

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter Q_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  requester presents a command this cycle.
REQ-006 cmd_op  input  2  ALU control: 0 add, 1 sub, 2 mul, 3 invalid.
REQ-007 cmd_x  input  WIDTH  operand x.
REQ-008 cmd_z  input  WIDTH  operand z.
REQ-009 cmd_ready  output  1  queue can accept a command (count < Q_DEPTH).
REQ-010 number_queued  output  clog2(Q_DEPTH)+1  commands currently in the queue.
REQ-011 q_full  output  1  number_queued == Q_DEPTH.
REQ-012 drop_cnt  output  8  saturating count of commands rejected because the queue was full.
REQ-013 res_valid  output  1  result held and valid.
REQ-014 res_ready  input  1  consumer accepts the result.
REQ-015 res_y  output  2*WIDTH  result.
REQ-016 res_err  output  1  result belongs to an invalid-opcode command.

Function
REQ-017 Push: cmd_valid && cmd_ready at an edge writes {op,x,z} at the tail and advances the tail pointer (wraps Q_DEPTH-1 -> 0).
REQ-018 cmd_ready is combinational from the registered count only; it does not depend on a same-cycle pop.
REQ-019 cmd_valid && !cmd_ready increments drop_cnt (saturates at 255); the queue is unchanged.
REQ-020 Simultaneous push and pop leave number_queued unchanged; push-only +1; pop-only -1.
REQ-021 FSM states: IDLE, EXEC, MUL2, RESP.
REQ-022 IDLE: if number_queued > 0, pop the head into operand registers and go to EXEC; otherwise stay in IDLE.
REQ-023 EXEC: op 0 -> res_y = zero-extended x + z; op 1 -> res_y = (x - z) mod 2^(2*WIDTH); op 3 -> res_y = 0, res_err = 1; go to RESP. For op 2, go to MUL2.
REQ-024 MUL2: res_y = full unsigned product x*z (2*WIDTH bits); go to RESP.
REQ-025 RESP: res_valid = 1, and res_y/res_err are held stable; on res_ready go to IDLE with res_valid = 0 next cycle; otherwise stay.
REQ-026 Latency: with the queue empty and the FSM in IDLE, res_valid rises 3 edges after the accepting edge for add/sub/invalid, and 4 edges for mul.
REQ-027 Commands complete strictly in acceptance order; at most one command is in flight outside the queue.
REQ-028 While the FSM is in EXEC, MUL2 or RESP, pushes continue to be accepted up to Q_DEPTH.
REQ-029 res_err is cleared when the next command enters EXEC.

Reset
REQ-030 rst at an edge forces: state IDLE, head/tail/number_queued 0, q_full 0, cmd_ready 1, drop_cnt 0, res_valid 0, res_y 0, res_err 0.
REQ-031 rst has priority over push, pop and FSM transitions. Reset mid-operation discards queued and in-flight commands; no result is produced for them.

Verification
REQ-032 Single add, WIDTH=8: push op0 x=200 z=100, res_ready=1 -> res_valid at accept+3, res_y=300, res_err=0.
REQ-033 Sub wrap: op1 x=5 z=7 -> res_y=16'hFFFE. Mul: op2 x=255 z=255 -> res_y=16'hFE01, at accept+4.
REQ-034 Fill and overflow: hold res_ready=0 and push 6 commands back-to-back -> 1 in flight plus 4 queued; cmd_ready=0 and q_full=1 after that; the sixth push is dropped; drop_cnt=1; results drain in push order.
REQ-035 Invalid opcode: op3 x=9 z=9 -> res_valid with res_y=0, res_err=1; the following op0 x=1 z=1 -> res_y=2, res_err=0.
REQ-036 Backpressure: hold res_ready=0 for 10 cycles in RESP -> res_valid, res_y and res_err are stable throughout; release -> res_valid=0 next cycle.
REQ-037 Reset mid-run: assert rst while in MUL2 with 3 commands queued -> next cycle all outputs are at their reset values, and no stale result ever appears.
